// File: rtl/thunder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : thunder_pkg
//  Description : Shared TSIP constants and frame-FSM state encoding for the
//                Thunderbolt GPS link (transmit and receive blocks).
//  Revision    : 1.0 - initial release
// ============================================================================
package thunder_pkg;

    localparam logic [7:0] TSIP_DLE = 8'h10;
    localparam logic [7:0] TSIP_ETX = 8'h03;
    localparam int         MAX_LEN  = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SOF_DLE    = 4'd1,
        ST_ID         = 4'd2,
        ST_ID_STUFF   = 4'd3,
        ST_DATA       = 4'd4,
        ST_DATA_STUFF = 4'd5,
        ST_EOF_DLE    = 4'd6,
        ST_EOF_ETX    = 4'd7,
        ST_DONE       = 4'd8
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 UART byte serializer; supports back-to-back bytes with no
//                idle bits between a stop bit and the next start bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_ready,
    output logic       o_byte_done
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic               r_active;
    logic [3:0]         r_bit;
    logic [c_CNT_W-1:0] r_cnt;
    logic [8:0]         r_shift;
    logic               r_tx;
    logic               w_last;
    logic               w_load;

    // Ready during the final stop-bit cycle so the next start bit follows directly.
    assign w_last      = r_active && (r_bit == 4'd9) && (r_cnt == c_CNT_LAST);
    assign o_ready     = !r_active || w_last;
    assign w_load      = i_start && o_ready;
    assign o_byte_done = w_last;
    assign o_tx        = r_tx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_bit    <= 4'd0;
            r_cnt    <= '0;
            r_shift  <= 9'h1FF;
            r_tx     <= 1'b1;
        end else if (w_load) begin
            r_active <= 1'b1;
            r_bit    <= 4'd0;
            r_cnt    <= '0;
            r_shift  <= {1'b1, i_byte};
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/thunder_tsip_tx.sv
`default_nettype none
// ============================================================================
//  Module      : thunder_tsip_tx
//  Description : TSIP command framer (DLE/ETX with DLE stuffing) feeding an
//                8N1 UART toward the Thunderbolt RX pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module thunder_tsip_tx
    import thunder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_id,
    input  logic [3:0]  i_cmd_len,
    input  logic [63:0] i_cmd_payload,
    output logic        o_tx_thunder,
    output logic        o_busy,
    output logic        o_done
);

    frame_state_t r_state;
    logic [7:0]   r_id;
    logic [3:0]   r_len;
    logic [63:0]  r_payload;
    logic [2:0]   r_idx;
    logic         r_arm;
    logic         r_kick;
    logic         r_ready;
    logic         r_busy;
    logic         r_done;

    frame_state_t w_next_state;
    logic [2:0]   w_next_idx;
    logic [7:0]   w_cur_data;
    logic [7:0]   w_next_data;
    logic         w_idx_last;
    logic         w_accept;
    logic         w_start;
    logic [7:0]   w_tx_byte;
    logic         w_ser_ready;
    logic         w_byte_done;

    function automatic logic [7:0] f_frame_byte(frame_state_t s, logic [7:0] id, logic [7:0] data);
        case (s)
            ST_ID:      return id;
            ST_DATA:    return data;
            ST_EOF_ETX: return TSIP_ETX;
            default:    return TSIP_DLE;
        endcase
    endfunction

    assign w_accept    = i_cmd_valid && r_ready;
    assign w_cur_data  = r_payload[{r_idx, 3'b000} +: 8];
    assign w_next_data = r_payload[{w_next_idx, 3'b000} +: 8];
    assign w_idx_last  = ({1'b0, r_idx} == (r_len - 4'd1));

    // Successor of the byte currently on the wire.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            ST_SOF_DLE:  w_next_state = ST_ID;
            ST_ID: begin
                w_next_idx = 3'd0;
                if (r_id == TSIP_DLE)    w_next_state = ST_ID_STUFF;
                else if (r_len == 4'd0)  w_next_state = ST_EOF_DLE;
                else                     w_next_state = ST_DATA;
            end
            ST_ID_STUFF: begin
                w_next_idx   = 3'd0;
                w_next_state = (r_len == 4'd0) ? ST_EOF_DLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_cur_data == TSIP_DLE) begin
                    w_next_state = ST_DATA_STUFF;
                end else if (w_idx_last) begin
                    w_next_state = ST_EOF_DLE;
                end else begin
                    w_next_state = ST_DATA;
                    w_next_idx   = r_idx + 3'd1;
                end
            end
            ST_DATA_STUFF: begin
                if (w_idx_last) begin
                    w_next_state = ST_EOF_DLE;
                end else begin
                    w_next_state = ST_DATA;
                    w_next_idx   = r_idx + 3'd1;
                end
            end
            ST_EOF_DLE:  w_next_state = ST_EOF_ETX;
            ST_EOF_ETX:  w_next_state = ST_DONE;
            default:     w_next_state = r_state;
        endcase
    end

    // r_kick launches the SOF byte; every later byte is issued in the cycle its predecessor completes.
    assign w_tx_byte = f_frame_byte(r_kick ? ST_SOF_DLE : w_next_state, r_id, w_next_data);
    assign w_start   = w_ser_ready && (r_kick || (w_byte_done && (w_next_state != ST_DONE)));

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_byte_tx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_byte      (w_tx_byte),
        .o_tx        (o_tx_thunder),
        .o_ready     (w_ser_ready),
        .o_byte_done (w_byte_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_len     <= '0;
            r_payload <= '0;
            r_idx     <= '0;
            r_arm     <= 1'b0;
            r_kick    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_arm  <= 1'b0;
            r_kick <= r_arm;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        r_id      <= i_cmd_id;
                        r_len     <= (i_cmd_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : i_cmd_len;
                        r_payload <= i_cmd_payload;
                        r_idx     <= 3'd0;
                        r_state   <= ST_SOF_DLE;
                        r_arm     <= 1'b1;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    if (w_byte_done) begin
                        r_state <= w_next_state;
                        r_idx   <= w_next_idx;
                        if (w_next_state == ST_DONE) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_thunder_tsip_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thunder_tsip_tx
//  Description : Self-checking bench: cycle-exact line model plus UART decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thunder_tsip_tx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_id = 8'h00;
    logic [3:0]  cmd_len = 4'd0;
    logic [63:0] cmd_payload = 64'h0;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] next_bytes[$];
    logic [7:0] rx_q[$];
    bit         model_on = 1'b0;
    int         m = 0;
    int         end_m = 0;
    logic [3:0] act_v;
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    thunder_tsip_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_id      (cmd_id),
        .i_cmd_len     (cmd_len),
        .i_cmd_payload (cmd_payload),
        .o_tx_thunder  (tx),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wire bytes of a TSIP frame, built straight from the framing rules.
    task automatic build(input logic [7:0] id, input int len, input logic [63:0] pl);
        int n;
        logic [7:0] b;
        n = (len > 8) ? 8 : len;
        next_bytes = {};
        next_bytes.push_back(8'h10);
        next_bytes.push_back(id);
        if (id == 8'h10) next_bytes.push_back(8'h10);
        for (int k = 0; k < n; k++) begin
            b = pl[8*k +: 8];
            next_bytes.push_back(b);
            if (b == 8'h10) next_bytes.push_back(8'h10);
        end
        next_bytes.push_back(8'h10);
        next_bytes.push_back(8'h03);
    endtask

    // Expected line level m cycles after the accept edge.
    function automatic logic exp_line(input int mm);
        int bi;
        int pos;
        logic [7:0] b8;
        if (mm < 2) return 1'b1;
        bi = (mm - 2) / CPB;
        if (bi >= 10 * exp_bytes.size()) return 1'b1;
        pos = bi % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b8 = exp_bytes[bi / 10];
        return b8[pos - 1];
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            act_v = {tx, busy, cmd_ready, done};
            exp_v = {exp_line(m), (m < end_m), (m >= end_m), (m == end_m)};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL frame_cycle m=%0d: got tx/busy/ready/done=%b expected %b", m, act_v, exp_v);
                model_on = 1'b0;
            end
            if (m == end_m) model_on = 1'b0;
            m++;
        end
    end

    initial begin : uart_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                chk("start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", tx, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    // Call just after a negedge; returns one #1 after the accept edge.
    task automatic send(input logic [7:0] id, input logic [3:0] len, input logic [63:0] pl);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_send", cmd_ready, 1'b1);
        build(id, int'(len), pl);
        cmd_id      = id;
        cmd_len     = len;
        cmd_payload = pl;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_id      = ~id;
        cmd_payload = ~pl;
        exp_bytes   = next_bytes;
        m           = 0;
        end_m       = 2 + 10 * exp_bytes.size() * CPB;
        model_on    = 1'b1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 30000) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
        if (lat >= 30000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 30000 cycles");
        end
    endtask

    task automatic check_rx(input string name, input int n, input logic [127:0] exp);
        chk($sformatf("%s_count", name), rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp[8*(n-1-i) +: 8]);
        rx_q.delete();
    endtask

    task automatic idle_watch(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // len 0, then a stuffed frame accepted in the done cycle
        send(8'h1F, 4'd0, 64'h0);
        chk("model_len0_size", exp_bytes.size(), 4);
        wait_done(lat);
        chk("len0_latency", lat, 642);
        send(8'h8E, 4'd2, 64'h10A5);
        check_rx("len0", 4, 128'h10_1F_10_03);
        wait_done(lat);
        chk("stuff_payload_latency", lat, 1122);
        @(negedge clk);
        check_rx("stuff_payload", 7, 128'h10_8E_A5_10_10_10_03);

        send(8'h10, 4'd1, 64'h10);
        wait_done(lat);
        chk("stuff_id_latency", lat, 1122);
        @(negedge clk);
        check_rx("stuff_id", 7, 128'h10_10_10_10_10_10_03);

        send(8'h47, 4'd12, 64'h0807060504030201);
        wait_done(lat);
        chk("clamp_latency", lat, 1922);
        @(negedge clk);
        check_rx("clamp", 12, 128'h10_47_01_02_03_04_05_06_07_08_10_03);

        // command offered mid-frame must be ignored
        send(8'h8E, 4'd2, 64'h10A5);
        repeat (100) @(negedge clk);
        cmd_id      = 8'h55;
        cmd_len     = 4'd1;
        cmd_payload = 64'h77;
        cmd_valid   = 1'b1;
        repeat (20) @(negedge clk);
        cmd_valid   = 1'b0;
        wait_done(lat);
        idle_watch("ignored_cmd_idle", 200);
        check_rx("ignored_cmd", 7, 128'h10_8E_A5_10_10_10_03);

        // reset during the third byte's data bits
        send(8'h47, 4'd12, 64'h0807060504030201);
        repeat (360) @(negedge clk);
        model_on = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_tx", tx, 1'b1);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle_watch("midreset_no_done", 300);
        rx_q.delete();
        send(8'h10, 4'd1, 64'h10);
        wait_done(lat);
        chk("after_reset_latency", lat, 1122);
        @(negedge clk);
        check_rx("after_reset", 7, 128'h10_10_10_10_10_10_03);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
